fir_band_scheduler: RTL

Time-multiplexed sequencer for the 4-band 10-bit fixed-point FIR bank (delta/theta/alpha/beta-style bands, 30 taps each). One shared multiply-accumulate unit evaluates all bands, instead of one parallel transposed-form filter per band. The block stores the sample history and walks band × tap. It drives coefficient-ROM addresses, MAC operands and controls, and collects the four band results behind valid/ready handshakes. It sits between the sample source (ADC front end) and the band-power stage.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_hist_buf.sv | 43 ++++
 rtl/fir_band_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fir_pkg
// Purpose  : Shared sizes and FSM encoding for the time-multiplexed FIR bank
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int ORDER     = 30;
    localparam int NUM_BANDS = 4;
    localparam int DW        = 10;
    localparam int ADDR_W    = 7;
    localparam int PTR_W     = $clog2(ORDER);
    localparam int TAP_W     = PTR_W;
    localparam int BAND_W    = $clog2(NUM_BANDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ORDER - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_hist_buf.sv
`default_nettype none
// ============================================================================
// Module   : fir_hist_buf
// Purpose  : ORDER-deep circular sample history, read by distance from newest
// Revision : 1.0 - initial release
// ============================================================================
module fir_hist_buf
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_data,
    input  logic [TAP_W-1:0] rd_tap,
    output logic [DW-1:0]    rd_data
);

    logic [DW-1:0]    r_mem [ORDER];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_newest_ptr;
    logic [PTR_W-1:0] w_rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_newest_ptr <= '0;
        end else if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_newest_ptr    <= r_wr_ptr;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
        end
    end

    // Modulo-2^PTR_W wrap is harmless: the true index always lands in 0..ORDER-1
    assign w_rd_idx = r_newest_ptr - rd_tap
                    + ((r_newest_ptr < rd_tap) ? PTR_W'(ORDER) : '0);
    assign rd_data  = r_mem[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/fir_band_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_band_scheduler
// Purpose  : Band x tap sequencer driving one shared MAC for a 4-band FIR bank
// Revision : 1.0 - initial release
// ============================================================================
module fir_band_scheduler
    import fir_pkg::*;
#(
    parameter int MAC_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    output logic [ADDR_W-1:0]       coef_addr,
    output logic [DW-1:0]           hist_data,
    output logic                    mac_clr,
    output logic                    mac_en,
    input  logic [DW-1:0]           mac_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_BANDS*DW-1:0] band_data
);

    localparam int                 DRAIN_W      = 3;
    localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);
    localparam logic [TAP_W-1:0]   C_TAP_LAST   = TAP_W'(ORDER - 1);
    localparam logic [BAND_W-1:0]  C_BAND_LAST  = BAND_W'(NUM_BANDS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BAND_W-1:0]       r_band;
    logic [TAP_W-1:0]        r_tap;
    logic [DRAIN_W-1:0]      r_drain;
    logic [NUM_BANDS*DW-1:0] r_band_data;
    logic                    w_accept;
    logic                    w_drain_last;

    assign w_drain_last = (r_drain == C_DRAIN_LAST);
    assign coef_addr    = ADDR_W'(r_band) * ADDR_W'(ORDER) + ADDR_W'(r_tap);
    assign band_data    = r_band_data;

    fir_hist_buf u_hist (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_accept),
        .wr_data (in_data),
        .rd_tap  (r_tap),
        .rd_data (hist_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en  = 1'b1;
                mac_clr = (r_tap == '0);
                if (r_tap == C_TAP_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_last) begin
                    w_state_nxt = (r_band == C_BAND_LAST) ? ST_DONE : ST_MAC;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_band      <= '0;
            r_tap       <= '0;
            r_drain     <= '0;
            r_band_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_band <= '0;
                        r_tap  <= '0;
                    end
                end
                ST_MAC: begin
                    if (r_tap == C_TAP_LAST) begin
                        r_tap   <= '0;
                        r_drain <= '0;
                    end else begin
                        r_tap <= r_tap + TAP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_drain <= r_drain + DRAIN_W'(1);
                    // The last drain cycle is when the final tap's sum reaches mac_result
                    if (w_drain_last) begin
                        r_band_data[r_band*DW +: DW] <= mac_result;
                        if (r_band != C_BAND_LAST) begin
                            r_band <= r_band + BAND_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_band <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
